// File: rtl/popcount_pkg.sv
// Shared types and helpers for the streaming population counter:
// FSM state encoding, chunk-count helper and a width-parameterised saturating adder.
package popcount_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        HOLD
    } state_t;

    // Widest accumulator the saturating adder supports.
    localparam int SAT_MAXW = 32;

    function automatic int nchunk(input int data_width, input int chunk_width);
        return data_width / chunk_width;
    endfunction

    // Returns {saturated, value}; value clamps to 2^width-1 when a+b overflows width bits.
    function automatic logic [SAT_MAXW:0] sat_add(
        input logic [SAT_MAXW-1:0] a,
        input logic [SAT_MAXW-1:0] b,
        input int unsigned         width
    );
        logic [SAT_MAXW:0] sum;
        logic [SAT_MAXW:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = ((SAT_MAXW+1)'(1) << width) - (SAT_MAXW+1)'(1);
        if (sum > lim) begin
            return {1'b1, lim[SAT_MAXW-1:0]};
        end
        return {1'b0, sum[SAT_MAXW-1:0]};
    endfunction

endpackage

// File: rtl/popcount_stream_chunk.sv
// Combinational ones-counter for a single W-bit chunk; the only popcount
// logic in the stream block, shared across all chunk positions.
module chunk_popcount #(
    parameter int W = 8
) (
    input  logic [W-1:0]         data_i,
    output logic [$clog2(W):0]   count_o
);

    localparam int CW = $clog2(W) + 1;

    always_comb begin
        count_o = '0;
        for (int i = 0; i < W; i++) begin
            count_o = count_o + CW'(data_i[i]);
        end
    end

endmodule

// File: rtl/popcount_stream.sv
// Streaming population counter: counts one CHUNK_WIDTH slice per cycle and
// reports per-word counts or a saturating per-packet total over valid/ready.
module popcount_stream
    import popcount_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int CHUNK_WIDTH = 8,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    input  logic                  mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CNT_WIDTH-1:0]  out_count,
    output logic                  out_sat
);

    localparam int NCHUNK = nchunk(DATA_WIDTH, CHUNK_WIDTH);
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int PCW    = $clog2(CHUNK_WIDTH) + 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    if (DATA_WIDTH % CHUNK_WIDTH != 0) begin : g_bad_chunk
        $error("DATA_WIDTH must be a multiple of CHUNK_WIDTH");
    end
    if (CNT_WIDTH < $clog2(DATA_WIDTH) + 1) begin : g_bad_cnt
        $error("CNT_WIDTH too narrow for a full word count");
    end
    if (CNT_WIDTH > SAT_MAXW) begin : g_bad_cnt_max
        $error("CNT_WIDTH exceeds the saturating adder width");
    end

    state_t                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic                   last_q, last_d;
    logic                   mode_q, mode_d;
    logic                   open_q, open_d;
    logic [IDXW-1:0]        idx_q, idx_d;
    logic [CNT_WIDTH-1:0]   acc_q, acc_d;
    logic                   sat_q, sat_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   osat_q, osat_d;

    logic [CHUNK_WIDTH-1:0] chunk_arr [NCHUNK];
    logic [CHUNK_WIDTH-1:0] chunk_sel;
    logic [PCW-1:0]         chunk_cnt;
    logic [SAT_MAXW-1:0]    acc_ext;
    logic [SAT_MAXW-1:0]    pc_ext;
    logic [SAT_MAXW:0]      sum;
    logic                   sum_unused;

    genvar gi;
    for (gi = 0; gi < NCHUNK; gi++) begin : g_chunk
        assign chunk_arr[gi] = data_q[gi*CHUNK_WIDTH +: CHUNK_WIDTH];
    end
    assign chunk_sel = chunk_arr[idx_q];

    chunk_popcount #(
        .W (CHUNK_WIDTH)
    ) u_chunk (
        .data_i  (chunk_sel),
        .count_o (chunk_cnt)
    );

    assign sum_unused = ^(sum >> CNT_WIDTH);

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        last_d  = last_q;
        mode_d  = mode_q;
        open_d  = open_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        sat_d   = sat_q;
        cnt_d   = cnt_q;
        osat_d  = osat_q;

        acc_ext = '0;
        pc_ext  = '0;
        acc_ext[CNT_WIDTH-1:0] = acc_q;
        pc_ext[PCW-1:0]        = chunk_cnt;
        sum = sat_add(acc_ext, pc_ext, CNT_WIDTH);

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    last_d  = in_last;
                    // Only the first word of a packet decides the mode.
                    if (!open_q) begin
                        mode_d = mode;
                    end
                    idx_d   = '0;
                    state_d = COUNT;
                end
            end
            COUNT: begin
                acc_d = sum[CNT_WIDTH-1:0];
                sat_d = sat_q | sum[SAT_MAXW];
                if (idx_q == LAST_IDX) begin
                    idx_d = '0;
                    if (!mode_q || last_q) begin
                        state_d = HOLD;
                        cnt_d   = acc_d;
                        osat_d  = sat_d;
                        open_d  = 1'b0;
                    end else begin
                        state_d = IDLE;
                        open_d  = 1'b1;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    acc_d   = '0;
                    sat_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            data_q  <= '0;
            last_q  <= 1'b0;
            mode_q  <= 1'b0;
            open_q  <= 1'b0;
            idx_q   <= '0;
            acc_q   <= '0;
            sat_q   <= 1'b0;
            cnt_q   <= '0;
            osat_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            last_q  <= last_d;
            mode_q  <= mode_d;
            open_q  <= open_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            sat_q   <= sat_d;
            cnt_q   <= cnt_d;
            osat_q  <= osat_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign out_count = cnt_q;
    assign out_sat   = osat_q;

endmodule
